// File: rtl/arb_pkg.sv
// Shared types for the 4-channel round-robin arbiter.
package arb_pkg;
  localparam int CH_N = 4;

  typedef logic [1:0] ch_idx_t;
endpackage

// File: rtl/rr_pick_4.sv
// Combinational round-robin pick: rotate requests so ptr is bit 0,
// fixed-priority search, then add ptr back to get the absolute index.
module rr_pick_4
  import arb_pkg::*;
(
  input  logic [CH_N-1:0] req,
  input  ch_idx_t         ptr,
  output ch_idx_t         gnt_idx,
  output logic            gnt_any
);

  logic [CH_N-1:0] rot;
  ch_idx_t         off;

  always_comb begin
    rot = '0;
    for (int k = 0; k < CH_N; k++) begin
      rot[k] = req[ch_idx_t'(ptr + ch_idx_t'(k))];
    end
  end

  // Scan downward so the lowest set rotated bit is the last one written.
  always_comb begin
    off = '0;
    for (int k = CH_N - 1; k >= 0; k--) begin
      if (rot[k]) off = ch_idx_t'(k);
    end
  end

  assign gnt_idx = ptr + off;
  assign gnt_any = |req;

endmodule

// File: rtl/arb_rr_4.sv
// Four-channel round-robin arbiter with a registered output stage and a
// combinational grant index that drives a downstream 4:1 mux select.
module arb_rr_4
  import arb_pkg::*;
#(
  parameter int W = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [CH_N-1:0] in_valid,
  output logic [CH_N-1:0] in_ready,
  input  logic [W-1:0]    in_data0,
  input  logic [W-1:0]    in_data1,
  input  logic [W-1:0]    in_data2,
  input  logic [W-1:0]    in_data3,
  output ch_idx_t         sel,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [W-1:0]    out_data,
  output ch_idx_t         out_id
);

  ch_idx_t        ptr_q, ptr_d;
  logic           ov_q, ov_d;
  logic [W-1:0]   od_q, od_d;
  ch_idx_t        oid_q, oid_d;

  ch_idx_t        gnt_idx;
  logic           gnt_any;
  logic           can_load;
  logic           xfer;
  logic [W-1:0]   pick_data;

  rr_pick_4 u_pick (
    .req     (in_valid),
    .ptr     (ptr_q),
    .gnt_idx (gnt_idx),
    .gnt_any (gnt_any)
  );

  assign can_load = !ov_q || out_ready;
  assign xfer     = can_load && gnt_any;
  assign sel      = gnt_any ? gnt_idx : ptr_q;
  assign in_ready = xfer ? (CH_N'(1) << gnt_idx) : '0;

  always_comb begin
    if (gnt_idx == 2'd0)      pick_data = in_data0;
    else if (gnt_idx == 2'd1) pick_data = in_data1;
    else if (gnt_idx == 2'd2) pick_data = in_data2;
    else                      pick_data = in_data3;
  end

  // A load overrides a drain in the same edge, so out_valid stays high.
  always_comb begin
    ptr_d = ptr_q;
    ov_d  = ov_q;
    od_d  = od_q;
    oid_d = oid_q;
    if (xfer) begin
      od_d  = pick_data;
      oid_d = gnt_idx;
      ov_d  = 1'b1;
      ptr_d = gnt_idx + 2'd1;
    end else if (ov_q && out_ready) begin
      ov_d  = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q <= '0;
      ov_q  <= 1'b0;
      od_q  <= '0;
      oid_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      ov_q  <= ov_d;
      od_q  <= od_d;
      oid_q <= oid_d;
    end
  end

  assign out_valid = ov_q;
  assign out_data  = od_q;
  assign out_id    = oid_q;

endmodule

// File: tb/tb_arb_rr_4.sv
// Bench for arb_rr_4: directed vector table, reset sequence, and a random
// fairness run checked against a priority-order reference model.
module tb_arb_rr_4;
  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [3:0]   in_valid, in_ready;
  logic [W-1:0] in_data0, in_data1, in_data2, in_data3;
  logic [1:0]   sel, out_id;
  logic         out_valid, out_ready;
  logic [W-1:0] out_data;

  always #5 clk = ~clk;

  arb_rr_4 #(.W(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_data0(in_data0), .in_data1(in_data1),
    .in_data2(in_data2), .in_data3(in_data3),
    .sel(sel), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_id(out_id)
  );

  typedef struct {
    logic [3:0]  v;
    logic [15:0] d;
    logic        o;
    logic [1:0]  sel;
    logic [3:0]  rdy;
    logic        ov;
    logic [3:0]  od;
    logic [1:0]  oid;
  } tv_t;

  int checks = 0;
  int failures = 0;

  // Reference state: pointer and the held output beat.
  logic [1:0]   m_ptr = 2'd0;
  logic         m_ov  = 1'b0;
  logic [W-1:0] m_data = '0;
  logic [1:0]   m_id  = 2'd0;
  logic [3:0]   last_rdy;

  function automatic int m_grant(input logic [3:0] v, input logic [1:0] p);
    for (int k = 0; k < 4; k++) begin
      int c;
      c = (int'(p) + k) % 4;
      if (v[c]) return c;
    end
    return -1;
  endfunction

  function automatic tv_t mk(input logic [3:0] v, input logic [15:0] d, input logic o,
                             input logic [1:0] s, input logic [3:0] r, input logic ov,
                             input logic [3:0] od, input logic [1:0] oid);
    tv_t t;
    t.v = v; t.d = d; t.o = o; t.sel = s; t.rdy = r; t.ov = ov; t.od = od; t.oid = oid;
    return t;
  endfunction

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic m_reset();
    m_ptr = 2'd0; m_ov = 1'b0; m_data = '0; m_id = 2'd0;
  endtask

  // Called at a negedge: drive, check combinational outputs, clock, check registers.
  task automatic apply(input logic [3:0] v, input logic [15:0] d, input logic o,
                       input bit use_tbl, input tv_t e, input string tag);
    int g;
    logic [1:0] xs;
    logic [3:0] xr;
    in_valid = v;
    {in_data3, in_data2, in_data1, in_data0} = d;
    out_ready = o;
    #1;
    g  = m_grant(v, m_ptr);
    xs = (g >= 0) ? 2'(g) : m_ptr;
    xr = ((!m_ov || o) && g >= 0) ? 4'(1 << g) : 4'b0000;
    chk({tag, ".sel"}, 32'(sel), use_tbl ? 32'(e.sel) : 32'(xs));
    chk({tag, ".in_ready"}, 32'(in_ready), use_tbl ? 32'(e.rdy) : 32'(xr));
    last_rdy = in_ready;
    @(posedge clk);
    if (xr != 4'b0000) begin
      m_data = d[g*W +: W];
      m_id   = 2'(g);
      m_ov   = 1'b1;
      m_ptr  = 2'(g + 1);
    end else if (m_ov && o) begin
      m_ov = 1'b0;
    end
    @(negedge clk);
    chk({tag, ".out_valid"}, 32'(out_valid), use_tbl ? 32'(e.ov) : 32'(m_ov));
    chk({tag, ".out_data"}, 32'(out_data), use_tbl ? 32'(e.od) : 32'(m_data));
    chk({tag, ".out_id"}, 32'(out_id), use_tbl ? 32'(e.oid) : 32'(m_id));
  endtask

  tv_t tbl[15];
  tv_t nul;

  initial begin
    logic [3:0]  nv, keep;
    logic [15:0] nd, pd;
    int gap;
    nul = mk(4'h0, 16'h0, 1'b0, 2'd0, 4'h0, 1'b0, 4'h0, 2'd0);

    // all four valid, out_ready high
    tbl[0]  = mk(4'hF, 16'hDCBA, 1'b1, 2'd0, 4'b0001, 1'b1, 4'hA, 2'd0);
    tbl[1]  = mk(4'hF, 16'hDCBA, 1'b1, 2'd1, 4'b0010, 1'b1, 4'hB, 2'd1);
    tbl[2]  = mk(4'hF, 16'hDCBA, 1'b1, 2'd2, 4'b0100, 1'b1, 4'hC, 2'd2);
    tbl[3]  = mk(4'hF, 16'hDCBA, 1'b1, 2'd3, 4'b1000, 1'b1, 4'hD, 2'd3);
    tbl[4]  = mk(4'hF, 16'hDCBA, 1'b1, 2'd0, 4'b0001, 1'b1, 4'hA, 2'd0);
    // back-pressure with channel 1 beat held
    tbl[5]  = mk(4'b0010, 16'hDC5A, 1'b1, 2'd1, 4'b0010, 1'b1, 4'h5, 2'd1);
    tbl[6]  = mk(4'b1001, 16'hDC5A, 1'b0, 2'd3, 4'b0000, 1'b1, 4'h5, 2'd1);
    tbl[7]  = mk(4'b1001, 16'hDC5A, 1'b0, 2'd3, 4'b0000, 1'b1, 4'h5, 2'd1);
    tbl[8]  = mk(4'b1001, 16'hDC5A, 1'b0, 2'd3, 4'b0000, 1'b1, 4'h5, 2'd1);
    tbl[9]  = mk(4'b1001, 16'hDC5A, 1'b1, 2'd3, 4'b1000, 1'b1, 4'hD, 2'd3);
    // wrap: bring ptr to 3, grant 3, then 0 wins over 3
    tbl[10] = mk(4'b0100, 16'hDC5A, 1'b1, 2'd2, 4'b0100, 1'b1, 4'hC, 2'd2);
    tbl[11] = mk(4'b1000, 16'hDC5A, 1'b1, 2'd3, 4'b1000, 1'b1, 4'hD, 2'd3);
    tbl[12] = mk(4'b1001, 16'hDC5A, 1'b1, 2'd0, 4'b0001, 1'b1, 4'hA, 2'd0);
    // drain without load, then idle
    tbl[13] = mk(4'b0000, 16'hDC5A, 1'b1, 2'd1, 4'b0000, 1'b0, 4'hA, 2'd0);
    tbl[14] = mk(4'b0000, 16'hDC5A, 1'b0, 2'd1, 4'b0000, 1'b0, 4'hA, 2'd0);

    rst = 1'b1;
    in_valid = '0; out_ready = 1'b0;
    in_data0 = '0; in_data1 = '0; in_data2 = '0; in_data3 = '0;
    last_rdy = '0;
    @(negedge clk);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data", 32'(out_data), 32'd0);
    chk("rst.out_id", 32'(out_id), 32'd0);
    chk("rst.sel", 32'(sel), 32'd0);
    chk("rst.in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;
    m_reset();

    for (int i = 0; i < 15; i++) begin
      apply(tbl[i].v, tbl[i].d, tbl[i].o, 1'b1, tbl[i], $sformatf("vec%0d", i));
    end

    // mid-stream reset: load a beat, then discard it
    apply(4'b0001, 16'hDC5A, 1'b0, 1'b1,
          mk(4'h0, 16'h0, 1'b0, 2'd0, 4'b0001, 1'b1, 4'hA, 2'd0), "pre_rst");
    in_valid = 4'b0000;
    rst = 1'b1;
    m_reset();
    #1;
    chk("mid_rst.out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst.out_data", 32'(out_data), 32'd0);
    chk("mid_rst.out_id", 32'(out_id), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    apply(4'b0000, 16'hDC5A, 1'b1, 1'b1,
          mk(4'h0, 16'h0, 1'b0, 2'd0, 4'b0000, 1'b0, 4'h0, 2'd0), "post_rst_idle");
    apply(4'b0100, 16'hDC5A, 1'b1, 1'b1,
          mk(4'h0, 16'h0, 1'b0, 2'd2, 4'b0100, 1'b1, 4'hC, 2'd2), "post_rst_ch2");

    // random run: ch0 always requesting, ch1-3 random but held until accepted
    keep = 4'b0000; pd = '0; gap = 0;
    for (int c = 0; c < 1000; c++) begin
      nv[0] = 1'b1;
      for (int i = 1; i < 4; i++) nv[i] = keep[i] ? 1'b1 : 1'($urandom_range(0, 1));
      for (int i = 0; i < 4; i++) nd[i*4 +: 4] = keep[i] ? pd[i*4 +: 4] : 4'($urandom);
      apply(nv, nd, ($urandom_range(0, 3) != 0), 1'b0, nul, "rnd");
      chk("rnd.onehot0", 32'($onehot0(last_rdy)), 32'd1);
      if (|(last_rdy & nv)) begin
        if (last_rdy[0]) begin
          chk("rnd.fair_gap", 32'(gap <= 3), 32'd1);
          gap = 0;
        end else begin
          gap++;
        end
      end
      keep = nv & ~last_rdy;
      pd = nd;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
